// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multicycle MIPS control FSM (Moore) with ALU function decode.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       memwrite_raw;
    logic       irwrite_raw;
    logic       regwrite_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite      = 1'b0;
        branch       = 1'b0;
        aluop        = 2'b00;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        case (state_q)
            S_FETCH:   begin irwrite_raw = 1'b1; pcwrite = 1'b1; alusrcb = 2'b01; end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB:   begin regwrite_raw = 1'b1; memtoreg = 1'b1; end
            S_MEMWR:   begin iord = 1'b1; memwrite_raw = 1'b1; end
            S_EXECUTE: begin alusrca = 1'b1; aluop = 2'b10; end
            S_ALUWB:   begin regwrite_raw = 1'b1; regdst = 1'b1; end
            S_BRANCH:  begin alusrca = 1'b1; branch = 1'b1; pcsrc = 2'b01; aluop = 2'b01; end
            S_ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
            S_ADDIWB:  regwrite_raw = 1'b1;
            S_JUMP:    begin pcwrite = 1'b1; pcsrc = 2'b10; end
            default:   ;
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // Write enables are gated by rst_n so an async reset mid-write cannot
    // expose the FETCH-state enables while the state register is held clear.
    assign pcen     = rst_n & (pcwrite | (branch & zero));
    assign memwrite = rst_n & memwrite_raw;
    assign irwrite  = rst_n & irwrite_raw;
    assign regwrite = rst_n & regwrite_raw;
    assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Directed self-checking bench for multicycle_controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int total;
    int bad;

    logic [5:0] funct_tab [6];
    logic [2:0] alu_tab   [6];

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        funct_tab[0] = 6'b100000; alu_tab[0] = 3'b010;
        funct_tab[1] = 6'b100010; alu_tab[1] = 3'b110;
        funct_tab[2] = 6'b100100; alu_tab[2] = 3'b000;
        funct_tab[3] = 6'b100101; alu_tab[3] = 3'b001;
        funct_tab[4] = 6'b101010; alu_tab[4] = 3'b111;
        funct_tab[5] = 6'b111111; alu_tab[5] = 3'b010;

        rst_n = 1'b0;
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_state", state, 0);
            chk("rst_pcen", pcen, 0);
            chk("rst_irwrite", irwrite, 0);
            chk("rst_alucontrol", alucontrol, 3'b010);
        end
        chk("rst_alusrcb", alusrcb, 2'b01);
        chk("rst_regwrite", regwrite, 0);
        chk("rst_memwrite", memwrite, 0);

        rst_n = 1'b1;
        #1;
        chk("fetch_pcen", pcen, 1);
        chk("fetch_irwrite", irwrite, 1);
        chk("fetch_state", state, 0);

        // lw: 0,1,2,3,4,0
        tick(); chk("lw_decode", state, 1); chk("lw_dec_alusrcb", alusrcb, 2'b11);
        tick(); chk("lw_memadr", state, 2); chk("lw_adr_alusrca", alusrca, 1);
                chk("lw_adr_alusrcb", alusrcb, 2'b10);
        tick(); chk("lw_memrd", state, 3); chk("lw_rd_iord", iord, 1);
        tick(); chk("lw_memwb", state, 4); chk("lw_wb_regwrite", regwrite, 1);
                chk("lw_wb_memtoreg", memtoreg, 1);
        tick(); chk("lw_back", state, 0);

        // sw, reset asserted asynchronously in MEMWR
        op = 6'b101011;
        tick(); chk("sw_decode", state, 1);
        tick(); chk("sw_memadr", state, 2);
        tick(); chk("sw_memwr", state, 5); chk("sw_memwrite", memwrite, 1);
                chk("sw_iord", iord, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_memwrite", memwrite, 0);
        chk("midrst_state", state, 0);
        chk("midrst_pcen", pcen, 0);
        tick(); chk("midrst_hold", state, 0);
        rst_n = 1'b1;

        // R-type sweep
        op = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            funct = funct_tab[i];
            tick(); chk("r_decode", state, 1);
            tick(); chk("r_execute", state, 6); chk("r_alucontrol", alucontrol, alu_tab[i]);
                    chk("r_alusrca", alusrca, 1);
            tick(); chk("r_aluwb", state, 7); chk("r_regdst", regdst, 1);
                    chk("r_regwrite", regwrite, 1);
            tick(); chk("r_back", state, 0);
        end

        // addi
        op = 6'b001000;
        tick(); chk("addi_decode", state, 1);
        tick(); chk("addi_ex", state, 9); chk("addi_alusrcb", alusrcb, 2'b10);
                chk("addi_alucontrol", alucontrol, 3'b010);
        tick(); chk("addi_wb", state, 10); chk("addi_regwrite", regwrite, 1);
                chk("addi_regdst", regdst, 0);
        tick(); chk("addi_back", state, 0);

        // beq taken, zero also high during DECODE
        op   = 6'b000100;
        zero = 1'b1;
        tick(); chk("beq_decode", state, 1); chk("beq_dec_pcen", pcen, 0);
        tick(); chk("beq_branch", state, 8); chk("beq_t_pcen", pcen, 1);
                chk("beq_pcsrc", pcsrc, 2'b01); chk("beq_alucontrol", alucontrol, 3'b110);
        tick(); chk("beq_back", state, 0);

        // beq not taken, then zero toggles within BRANCH
        zero = 1'b0;
        tick(); chk("beq2_decode", state, 1);
        tick(); chk("beq2_branch", state, 8); chk("beq_nt_pcen", pcen, 0);
        zero = 1'b1;
        #1 chk("beq_zero_live", pcen, 1);
        zero = 1'b0;
        tick(); chk("beq2_back", state, 0);

        // unknown op
        op = 6'b111111;
        tick(); chk("unk_decode", state, 1); chk("unk_regwrite", regwrite, 0);
                chk("unk_memwrite", memwrite, 0);
        tick(); chk("unk_back", state, 0);

        // jump
        op = 6'b000010;
        tick(); chk("j_decode", state, 1);
        tick(); chk("j_jump", state, 11); chk("j_pcen", pcen, 1); chk("j_pcsrc", pcsrc, 2'b10);
        tick(); chk("j_back", state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle MIPS control unit that sits directly upstream of the ALU. It decodes the instruction opcode and funct fields and sequences a Moore state machine through fetch, decode and execute steps. Each cycle it drives the ALU function select `alucontrol[2:0]` together with the datapath mux selects and write enables. It consumes the ALU `zero` flag to resolve `beq`.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single system clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `op` in 6: instruction[31:26], taken from the instruction register.
- `funct` in 6: instruction[5:0].
- `zero` in 1: ALU zero flag, same cycle.
- `pcen` out 1: PC write enable.
- `memwrite` out 1: data memory write.
- `irwrite` out 1: instruction register load.
- `regwrite` out 1: register file write.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `memtoreg` out 1: writeback select (0 = ALUOut, 1 = Data).
- `regdst` out 1: destination register select (0 = rt, 1 = rd).
- `alusrca` out 1: ALU A select (0 = PC, 1 = A register).
- `alusrcb` out 2: ALU B select (00 = B reg, 01 = 4, 10 = SignImm, 11 = SignImm<<2).
- `pcsrc` out 2: PC source select (00 = ALU, 01 = ALUOut, 10 = jump target).
- `alucontrol` out 3: ALU function (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).
- `state` out 4: current state encoding, for debug and the bench.

## Operation
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5.
  - EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11.
  - Codes 12–15 are illegal and go to FETCH on the next edge.
- Transitions:
  - FETCH→DECODE.
  - DECODE branches on `op`:
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000000 (R-type) → EXECUTE.
    - 000100 (beq) → BRANCH.
    - 001000 (addi) → ADDIEX.
    - 000010 (j) → JUMP.
    - Any other op → FETCH (instruction is a no-op).
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB.
  - EXECUTE→ALUWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP → FETCH.
- Outputs are Moore, combinational from `state`, except `alucontrol` and `pcen`.
  - Any output not listed for a state is 0.
- Per-state asserted outputs:
  - FETCH: irwrite, pcwrite, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca, alusrcb=10, aluop=00.
  - MEMRD: iord.
  - MEMWB: regwrite, memtoreg.
  - MEMWR: iord, memwrite.
  - EXECUTE: alusrca, aluop=10.
  - ALUWB: regwrite, regdst.
  - BRANCH: alusrca, branch, pcsrc=01, aluop=01.
  - ADDIEX: alusrca, alusrcb=10, aluop=00.
  - ADDIWB: regwrite.
  - JUMP: pcwrite, pcsrc=10.
- `pcen` = pcwrite | (branch & zero).
- ALU decode from the internal `aluop`:
  - aluop 00 → 010 (ADD).
  - aluop 01 → 110 (SUB).
  - aluop 10 → decode `funct`:
    - 100000 → 010; 100010 → 110.
    - 100100 → 000; 100101 → 001.
    - 101010 → 111.
    - Any other funct → 010.
- During `rst_n` low:
  - `pcen`, `memwrite`, `irwrite` and `regwrite` are forced to 0.
  - `state` = 0.
  - All other outputs take their FETCH values: alusrcb=01, alucontrol=010, everything else 0.

## Timing
- Reset: `state` clears immediately on `rst_n` falling, with no clock edge required.
  - The first rising edge after `rst_n` rises executes FETCH, so irwrite and pcen are seen high in that cycle.
- Cycles per instruction, counted from FETCH to the return to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
- `zero` is sampled combinationally in BRANCH only.
  - `zero` toggling in any other state has no effect on `pcen`.
- `op`/`funct` changes:
  - `op` is used only in DECODE and MEMADR.
  - `funct` is used only in EXECUTE.
- Reset asserted mid-instruction (any state) aborts that instruction, with no write enable glitching high.

## Test plan
- Reset and fetch: hold `rst_n`=0 for 3 cycles, then release.
  - During reset: state=0, pcen=0, irwrite=0, alucontrol=010.
  - First cycle after release: pcen=1, irwrite=1.
- lw sequence: op=100011.
  - States 0,1,2,3,4 then back to 0.
  - MEMRD has iord=1; MEMWB has regwrite=1 and memtoreg=1.
- R-type sweep: op=0, funct ∈ {100000, 100010, 100100, 100101, 101010, 111111}.
  - In EXECUTE, alucontrol = 010, 110, 000, 001, 111, 010 respectively.
  - ALUWB has regdst=1 and regwrite=1.
- beq, both outcomes: op=000100.
  - With zero=1 in BRANCH: pcen=1, pcsrc=01, alucontrol=110.
  - With zero=0: pcen=0.
  - zero=1 held during DECODE leaves pcen=0.
- Unknown op and jump:
  - op=111111: states go 0→1→0 with regwrite and memwrite never asserted.
  - op=000010: states go 0→1→11, with pcen=1 and pcsrc=10 in JUMP.
- Mid-op reset: assert `rst_n`=0 asynchronously during MEMWR (memwrite=1).
  - memwrite drops to 0 and state=0 before the next clock edge.
